// File: rtl/datapath_param.sv
// datapath_param: register file, ALU, status/IR, program counter and
// a req/ack data-memory port that stalls the control unit while busy.
module datapath_param #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = 8,
  parameter int IW   = 16,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] da,
  input  logic [RW-1:0] sa,
  input  logic [RW-1:0] sb,
  input  logic          w,
  input  logic [2:0]    fs,
  input  logic          ci,
  input  logic          a_sel,
  input  logic          b_sel,
  input  logic [DW-1:0] k,
  input  logic          sl,
  input  logic          il,
  input  logic [1:0]    pc_mode,
  input  logic [1:0]    cond,
  input  logic          mr,
  input  logic          mw,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] ir,
  output logic [3:0]    status,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  input  logic [RW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic {IDLE, BUSY} mst_t;

  // common width so PC<->F moves zero-extend or truncate cleanly
  localparam int XW = (AW > DW) ? AW : DW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [3:0]    st_q, st_d;
  mst_t          mst_q, mst_d;
  logic [DW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          req_q, req_d;
  logic [RW-1:0] dest_q, dest_d;

  logic [XW-1:0] pc_ext, f_ext;
  logic [DW-1:0] a_op, b_op, b_add, f;
  logic [DW:0]   sum;
  logic          cf, vf;
  logic [3:0]    flags;
  logic          mem_op;

  assign pc_ext = XW'(pc_q);
  assign f_ext  = XW'(f);
  assign a_op   = a_sel ? pc_ext[DW-1:0] : regs_q[sa];
  assign b_op   = b_sel ? k : regs_q[sb];
  assign mem_op = mr | mw;

  assign stall = ((mst_q == IDLE) & mem_op) |
                 ((mst_q == BUSY) & ~mem_ack);

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign status    = st_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_req   = req_q;
  assign dbg_data  = regs_q[dbg_sel];

  // ALU result and flags {V,N,C,Z}
  always_comb begin
    b_add = fs[0] ? ~b_op : b_op;
    sum   = {1'b0, a_op} + {1'b0, b_add} + {{DW{1'b0}}, ci};
    f     = '0;
    cf    = 1'b0;
    vf    = 1'b0;
    unique case (fs)
      3'b000, 3'b001: begin
        f  = sum[DW-1:0];
        cf = sum[DW];
        vf = (a_op[DW-1] == b_add[DW-1]) &&
             (f[DW-1] != a_op[DW-1]);
      end
      3'b010: f = a_op & b_op;
      3'b011: f = a_op | b_op;
      3'b100: f = a_op ^ b_op;
      3'b101: f = ~a_op;
      3'b110: begin
        f  = {a_op[DW-2:0], 1'b0};
        cf = a_op[DW-1];
      end
      3'b111: begin
        f  = {1'b0, a_op[DW-1:1]};
        cf = a_op[0];
      end
    endcase
    flags = {vf, f[DW-1], cf, (f == '0)};
  end

  // architectural state: registers, PC, status, IR
  always_comb begin
    regs_d = regs_q;
    if (w && !stall && !mem_op)
      regs_d[da] = f;
    if (mst_q == BUSY && mem_ack && !we_q)
      regs_d[dest_q] = mem_rdata;

    pc_d = pc_q;
    if (!stall) begin
      unique case (pc_mode)
        2'b00: pc_d = pc_q;
        2'b01: pc_d = pc_q + AW'(1);
        2'b10: pc_d = f_ext[AW-1:0];
        2'b11: pc_d = st_q[cond] ? f_ext[AW-1:0]
                                 : pc_q + AW'(1);
      endcase
    end

    st_d = (sl && !stall) ? flags : st_q;
    ir_d = (il && !stall) ? imem_data : ir_q;
  end

  // memory port: issue from IDLE, hold request until ack
  always_comb begin
    mst_d   = mst_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    dest_d  = dest_q;
    unique case (mst_q)
      IDLE: if (mem_op) begin
        mst_d   = BUSY;
        maddr_d = f;
        wdata_d = regs_q[sb];
        we_d    = mw;
        dest_d  = da;
        req_d   = 1'b1;
      end
      BUSY: if (mem_ack) begin
        mst_d = IDLE;
        req_d = 1'b0;
        we_d  = 1'b0;
      end
    endcase
  end

  // state update with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      st_q    <= '0;
      mst_q   <= IDLE;
      maddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      dest_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      st_q    <= st_d;
      mst_q   <= mst_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      dest_q  <= dest_d;
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: scoreboard bench for datapath_param
// (default parameters DW=8, NREG=8, AW=8, IW=16).
module tb_datapath_param;

  localparam int DW = 8;
  localparam int NREG = 8;
  localparam int AW = 8;
  localparam int IW = 16;
  localparam int RW = 3;

  logic          clk, rst;
  logic [RW-1:0] da, sa, sb, dbg_sel;
  logic          w, ci, a_sel, b_sel, sl, il, mr, mw;
  logic [2:0]    fs;
  logic [DW-1:0] k, mem_rdata;
  logic [1:0]    pc_mode, cond;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data, ir;
  logic [3:0]    status;
  logic [DW-1:0] mem_addr, mem_wdata, dbg_data;
  logic          mem_we, mem_req, mem_ack, stall;

  datapath_param #(.DW(DW), .NREG(NREG), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .da(da), .sa(sa), .sb(sb), .w(w),
    .fs(fs), .ci(ci), .a_sel(a_sel), .b_sel(b_sel), .k(k),
    .sl(sl), .il(il), .pc_mode(pc_mode), .cond(cond),
    .mr(mr), .mw(mw), .imem_addr(imem_addr),
    .imem_data(imem_data), .ir(ir), .status(status),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  int total = 0;
  int bad = 0;
  logic [31:0]   sb_q[$];
  logic [31:0]   exp_v;
  logic [DW-1:0] m_regs [NREG];
  logic [AW-1:0] m_pc;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] ref_alu(
    input logic [7:0] a, input logic [7:0] b,
    input logic [2:0] op, input logic c_in);
    int us, ss;
    logic [7:0] r;
    logic c, v;
    us = 0; ss = 0; r = 0; c = 0; v = 0;
    case (op)
      3'd0: begin
        us = int'(a) + int'(b) + int'(c_in);
        ss = int'($signed(a)) + int'($signed(b)) + int'(c_in);
        r = us[7:0]; c = (us > 255); v = (ss > 127) || (ss < -128);
      end
      3'd1: begin
        us = int'(a) + 255 - int'(b) + int'(c_in);
        ss = int'($signed(a)) - int'($signed(b)) - 1 + int'(c_in);
        r = us[7:0]; c = (us > 255); v = (ss > 127) || (ss < -128);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {v, r[7], c, (r == 8'h00), r};
  endfunction

  task automatic idle();
    w = 0; mr = 0; mw = 0; sl = 0; il = 0; pc_mode = 0;
    a_sel = 0; b_sel = 0; ci = 0; fs = 0; cond = 0;
    mem_ack = 0; da = 0; sa = 0; sb = 0; k = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; imem_data = 0; mem_rdata = 0; dbg_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (imem_addr !== 0 || status !== 0 || ir !== 0) begin
      bad++;
      $display("FAIL reset_pc_st_ir pc=%h st=%b ir=%h exp 0",
               imem_addr, status, ir);
    end
    total++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 ||
        mem_wdata !== 0 || stall !== 0) begin
      bad++;
      $display("FAIL reset_mem req=%b we=%b a=%h d=%h st=%b exp 0",
               mem_req, mem_we, mem_addr, mem_wdata, stall);
    end
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 0;
      dbg_sel = RW'(i); #1;
      total++;
      if (dbg_data !== 0) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h exp=00", i, dbg_data);
      end
    end
    m_pc = 0;
    @(negedge clk);
    rst = 0;
    step();
  endtask

  task automatic test_add_flags();
    idle();
    w = 1; da = 3; sa = 0; b_sel = 1; k = 8'h7F;
    sb_q.push_back(32'h7F); m_regs[3] = 8'h7F;
    step();
    idle();
    dbg_sel = 3; #1;
    exp_v = sb_q.pop_front();
    total++;
    if (dbg_data !== exp_v[7:0]) begin
      bad++;
      $display("FAIL add_r3 got=%h exp=%h", dbg_data, exp_v[7:0]);
    end
    sa = 3; b_sel = 1; k = 8'h01; sl = 1;
    step();
    idle();
    total++;
    if (status !== 4'b1100) begin
      bad++;
      $display("FAIL add_ovf_status got=%b exp=1100", status);
    end
  endtask

  task automatic test_sub_zero();
    idle();
    w = 1; da = 3; sa = 0; b_sel = 1; k = 8'h05;
    m_regs[3] = 8'h05;
    step();
    idle();
    sa = 3; sb = 3; fs = 3'd1; ci = 1; sl = 1;
    step();
    idle();
    total++;
    if (status !== 4'b0011) begin
      bad++;
      $display("FAIL sub_zero_status got=%b exp=0011", status);
    end
  endtask

  task automatic test_alu_ops();
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic       cv [4];
    logic [11:0] r;
    av = '{8'h7F, 8'h80, 8'h05, 8'hA5};
    bv = '{8'h01, 8'h80, 8'h05, 8'h3C};
    cv = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int op = 0; op < 8; op++) begin
      for (int p = 0; p < 4; p++) begin
        idle();
        w = 1; da = 1; sa = 0; b_sel = 1; k = av[p];
        m_regs[1] = av[p];
        step();
        idle();
        w = 1; da = 2; sa = 1; b_sel = 1; k = bv[p];
        fs = 3'(op); ci = cv[p]; sl = 1;
        r = ref_alu(av[p], bv[p], 3'(op), cv[p]);
        sb_q.push_back({20'h0, r});
        m_regs[2] = r[7:0];
        step();
        idle();
        dbg_sel = 2; #1;
        exp_v = sb_q.pop_front();
        total++;
        if (dbg_data !== exp_v[7:0] || status !== exp_v[11:8]) begin
          bad++;
          $display("FAIL alu_op%0d_p%0d got=%h/%b exp=%h/%b",
                   op, p, dbg_data, status, exp_v[7:0], exp_v[11:8]);
        end
      end
    end
  endtask

  task automatic test_pc_increment();
    logic [IW-1:0] first_ir;
    idle();
    pc_mode = 1; il = 1;
    for (int i = 0; i < 256; i++) begin
      imem_data = {m_pc ^ 8'h5A, m_pc};
      total++;
      if (imem_addr !== m_pc) begin
        bad++;
        $display("FAIL pc_inc_addr i=%0d got=%h exp=%h",
                 i, imem_addr, m_pc);
      end
      sb_q.push_back({16'h0, imem_data});
      step();
      m_pc = m_pc + 1'b1;
      exp_v = sb_q.pop_front();
      total++;
      if (ir !== exp_v[15:0]) begin
        bad++;
        $display("FAIL pc_inc_ir i=%0d got=%h exp=%h",
                 i, ir, exp_v[15:0]);
      end
    end
    idle();
    total++;
    if (imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL pc_wrap got=%h exp=00", imem_addr);
    end
    first_ir = ir;
    imem_data = 16'hBEEF;
    step();
    total++;
    if (ir !== first_ir || imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL ir_hold got=%h/%h exp=%h/00",
               ir, imem_addr, first_ir);
    end
  endtask

  task automatic test_branch();
    idle(); b_sel = 1; k = 8'h00; sl = 1;
    step();
    total++;
    if (status !== 4'b0001) begin
      bad++;
      $display("FAIL br_setz got=%b exp=0001", status);
    end
    idle(); b_sel = 1; k = 8'h40; pc_mode = 3; cond = 0;
    step(); m_pc = 8'h40;
    total++;
    if (imem_addr !== m_pc) begin
      bad++;
      $display("FAIL br_z_taken got=%h exp=%h", imem_addr, m_pc);
    end
    idle(); b_sel = 1; k = 8'h01; sl = 1;
    step();
    idle(); b_sel = 1; k = 8'h40; pc_mode = 3; cond = 0;
    step(); m_pc = 8'h41;
    total++;
    if (imem_addr !== m_pc) begin
      bad++;
      $display("FAIL br_z_not_taken got=%h exp=%h", imem_addr, m_pc);
    end
    idle(); b_sel = 1; k = 8'h80; sl = 1;
    step();
    idle(); b_sel = 1; k = 8'h10; pc_mode = 3; cond = 2;
    step(); m_pc = 8'h10;
    total++;
    if (imem_addr !== m_pc) begin
      bad++;
      $display("FAIL br_n_taken got=%h exp=%h", imem_addr, m_pc);
    end
    idle(); b_sel = 1; k = 8'h70; pc_mode = 3; cond = 1;
    step(); m_pc = 8'h11;
    total++;
    if (imem_addr !== m_pc) begin
      bad++;
      $display("FAIL br_c_not_taken got=%h exp=%h", imem_addr, m_pc);
    end
    idle(); b_sel = 1; k = 8'h00; pc_mode = 3; cond = 0; sl = 1;
    step(); m_pc = 8'h12;
    total++;
    if (imem_addr !== m_pc || status !== 4'b0001) begin
      bad++;
      $display("FAIL br_latched got=%h/%b exp=%h/0001",
               imem_addr, status, m_pc);
    end
    idle(); b_sel = 1; k = 8'h33; pc_mode = 2;
    step(); m_pc = 8'h33;
    total++;
    if (imem_addr !== m_pc) begin
      bad++;
      $display("FAIL pc_load got=%h exp=%h", imem_addr, m_pc);
    end
    idle(); a_sel = 1; b_sel = 1; k = 8'h02; pc_mode = 2;
    step(); m_pc = 8'h35;
    idle();
    total++;
    if (imem_addr !== m_pc) begin
      bad++;
      $display("FAIL pc_rel got=%h exp=%h", imem_addr, m_pc);
    end
  endtask

  task automatic test_mem_read();
    logic [AW-1:0] pc0;
    int nst, nrq;
    logic done, acked;
    idle();
    dbg_sel = 5;
    mr = 1; w = 1; da = 5; sa = 0; b_sel = 1; k = 8'h20; pc_mode = 1;
    sb_q.push_back(32'hA5);
    pc0 = m_pc; nst = 0; nrq = 0; done = 0;
    for (int c = 0; c < 12 && !done; c++) begin
      if (mem_req === 1'b1) begin
        nrq++;
        total++;
        if (mem_addr !== 8'h20 || mem_we !== 1'b0 ||
            imem_addr !== pc0 || dbg_data !== m_regs[5]) begin
          bad++;
          $display("FAIL rd_busy a=%h we=%b pc=%h r5=%h exp 20/0/%h/%h",
                   mem_addr, mem_we, imem_addr, dbg_data, pc0, m_regs[5]);
        end
      end
      if (nrq == 3) begin
        mem_ack = 1; mem_rdata = 8'hA5;
      end
      #1;
      if (stall === 1'b1) nst++;
      acked = mem_ack;
      step();
      if (acked) done = 1;
    end
    idle();
    m_pc = pc0 + 1'b1;
    exp_v = sb_q.pop_front();
    m_regs[5] = exp_v[7:0];
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rd_timeout got=no_ack_edge exp=ack_edge");
    end
    total++;
    if (nst != 3 || nrq != 3) begin
      bad++;
      $display("FAIL rd_counts stall=%0d req=%0d exp=3/3", nst, nrq);
    end
    total++;
    if (dbg_data !== exp_v[7:0] || mem_req !== 1'b0 ||
        imem_addr !== m_pc) begin
      bad++;
      $display("FAIL rd_done r5=%h req=%b pc=%h exp=%h/0/%h",
               dbg_data, mem_req, imem_addr, exp_v[7:0], m_pc);
    end
  endtask

  task automatic test_mem_write();
    idle();
    mr = 1; mw = 1; w = 1; da = 6; sa = 0; sb = 3;
    b_sel = 1; k = 8'h30;
    #1;
    total++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL wr_issue stall=%b req=%b exp=1/0", stall, mem_req);
    end
    step();
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h30 ||
        mem_wdata !== m_regs[3]) begin
      bad++;
      $display("FAIL wr_busy req=%b we=%b a=%h d=%h exp=1/1/30/%h",
               mem_req, mem_we, mem_addr, mem_wdata, m_regs[3]);
    end
    mem_ack = 1; mem_rdata = 8'hEE;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL wr_ack_stall got=%b exp=0", stall);
    end
    step();
    idle();
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL wr_done req=%b we=%b exp=0/0", mem_req, mem_we);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = RW'(i); #1;
      total++;
      if (dbg_data !== m_regs[i]) begin
        bad++;
        $display("FAIL wr_reg%0d got=%h exp=%h", i, dbg_data, m_regs[i]);
      end
    end
  endtask

  task automatic test_reset_busy();
    idle(); b_sel = 1; k = 8'h80; sl = 1;
    step();
    idle(); mr = 1; da = 4; b_sel = 1; k = 8'h50;
    step();
    total++;
    if (mem_req !== 1'b1 || status !== 4'b0100 || imem_addr !== m_pc) begin
      bad++;
      $display("FAIL rb_pre req=%b st=%b pc=%h exp=1/0100/%h",
               mem_req, status, imem_addr, m_pc);
    end
    #2;
    rst = 1;
    #1;
    total++;
    if (mem_req !== 1'b0 || imem_addr !== 0 || status !== 0 ||
        mem_addr !== 0) begin
      bad++;
      $display("FAIL rb_async req=%b pc=%h st=%b a=%h exp 0",
               mem_req, imem_addr, status, mem_addr);
    end
    idle();
    m_pc = 0;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 0;
      dbg_sel = RW'(i); #1;
      total++;
      if (dbg_data !== 0) begin
        bad++;
        $display("FAIL rb_reg%0d got=%h exp=00", i, dbg_data);
      end
    end
    @(negedge clk);
    rst = 0;
    mem_ack = 1; mem_rdata = 8'h77;
    step();
    mem_ack = 0;
    dbg_sel = 4; #1;
    total++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || dbg_data !== 0 ||
        imem_addr !== 0) begin
      bad++;
      $display("FAIL rb_late_ack req=%b st=%b r4=%h pc=%h exp 0",
               mem_req, stall, dbg_data, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_sub_zero();
    test_alu_ops();
    test_pc_increment();
    test_branch();
    test_mem_read();
    test_mem_write();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_param.md
Name: datapath_param

Overview:
Parametrised successor to the 8-bit CPU datapath. Contains:
- a register file and an ALU with operand muxes,
- a latched status register and an instruction register,
- a program counter with increment, load and conditional branch,
- a req/ack data-memory port with stall generation. This port replaces the tristate data bus.

It sits between the control unit, which supplies a decoded control word each cycle, and the external instruction and data memories.

Parameters:
DW, 8, data/register width in bits (>=4)
NREG, 8, number of registers (power of 2, >=2); RW = clog2(NREG)
AW, 8, program counter / instruction address width
IW, 16, instruction width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
da  in  RW  destination register
sa  in  RW  source A register
sb  in  RW  source B register
w  in  1  register write enable
fs  in  3  ALU function select
ci  in  1  ALU carry-in
a_sel  in  1  A operand: 0 = reg[sa], 1 = PC zero-extended/truncated to DW
b_sel  in  1  B operand: 0 = reg[sb], 1 = k
k  in  DW  immediate
sl  in  1  status latch enable
il  in  1  instruction register load
pc_mode  in  2  00 hold, 01 increment, 10 load F, 11 conditional branch
cond  in  2  branch flag select: 0 Z, 1 C, 2 N, 3 V
mr  in  1  memory read request
mw  in  1  memory write request
imem_addr  out  AW  instruction address (= PC)
imem_data  in  IW  instruction memory data
ir  out  IW  instruction register
status  out  4  latched flags {V,N,C,Z}
mem_addr  out  DW  data address
mem_wdata  out  DW  write data
mem_we  out  1  write strobe qualifier
mem_req  out  1  request, held until ack
mem_ack  in  1  completion; for reads, rdata is valid in the same cycle
mem_rdata  in  DW  read data
stall  out  1  control unit must hold its current control word
dbg_sel  in  RW  debug register select
dbg_data  out  DW  reg[dbg_sel], combinational

Behaviour:
- Reset (asynchronous, immediate): all registers, PC, ir, status, mem_addr, mem_wdata, mem_we and mem_req go to 0; memory FSM goes to IDLE.
- ALU (combinational; F is DW bits):
  - 000 ADD: A+B+ci
  - 001 SUB: A+~B+ci
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL A: C = A[DW-1]
  - 111 SHR A, logical: C = A[0]
- Flags:
  - Z = (F==0); N = F[DW-1].
  - C = carry-out for ADD/SUB and the shifted-out bit for shifts; 0 for logic ops.
  - V = signed overflow for ADD/SUB; 0 otherwise.
  - status is updated on the clock edge when sl=1 and stall=0.
- Register write: reg[da] <= F at the edge when w=1, stall=0 and mr=mw=0.
  - w is ignored in any cycle with mr or mw asserted.
  - No write bypass: a register read in the cycle it is written returns the old value.
- PC (AW bits, wraps 2^AW-1 -> 0), updates only when stall=0:
  - 00: hold
  - 01: PC+1
  - 10: F[AW-1:0], zero-extended if AW>DW
  - 11: F if status[cond]==1, else PC+1. The test uses the latched status, not this cycle's flags.
- ir <= imem_data at the edge when il=1 and stall=0.
- Memory FSM, states IDLE and BUSY:
  - IDLE with (mr|mw): latch mem_addr=F, mem_wdata=reg[sb], mem_we=mw, dest=da; set mem_req<=1; go to BUSY.
  - mr and mw both asserted: the access is a write.
  - BUSY: mem_req, mem_addr, mem_wdata and mem_we held stable.
  - BUSY with mem_ack=1: on a read, reg[dest] <= mem_rdata at that edge; mem_req<=0, mem_we<=0; go to IDLE.
  - mem_ack while IDLE: ignored.
  - stall = (IDLE & (mr|mw)) | (BUSY & ~mem_ack). Combinational; 0 out of reset when mr=mw=0.
  - Minimum access: 2 cycles (issue cycle plus one BUSY cycle with ack).
- Reset during BUSY aborts the access: mem_req drops asynchronously and no register is written.

Test Plan:
1. Reset; w=1, da=3, sa=0, b_sel=1, k=0x7F, fs=ADD, ci=0 -> r3=0x7F. Next: sa=3, k=0x01, sl=1 -> F=0x80, status {V,N,C,Z}=1100.
2. sa=sb=r3=0x05, fs=SUB, ci=1, sl=1 -> F=0x00, status Z=1, C=1, V=0, N=0.
3. pc_mode=01 for 256 cycles (AW=8) -> PC sequence 0x00..0xFF then 0x00; imem_addr tracks PC; il=1 -> ir holds the imem_data at the pre-edge address.
4. status Z=1, cond=0, pc_mode=11, F=0x40 -> PC=0x40. Then clear Z via sl; same control word from PC=0x40 -> PC=0x41.
5. mr=1, da=5, F=0x20, pc_mode=01, ack arrives in the 3rd BUSY cycle with rdata=0xA5:
   - stall high for 3 cycles (issue cycle plus 2 BUSY cycles without ack);
   - mem_req high for 3 cycles, addr 0x20, mem_we=0;
   - r5=0xA5 at the ack edge;
   - PC advances exactly once, at the ack edge.
   A write with mr=mw=1 -> mem_we=1, and no register changes.
6. rst asserted mid-BUSY -> mem_req, PC, status and all registers go to 0 asynchronously (before the next edge); a late mem_ack after reset is ignored.
